// File: rtl/motor_pkg.sv
// Shared types for the motor-path blocks: default widths, hall emulator FSM states and
// the latched pulse-train configuration together with its clamping rule.
package motor_pkg;

    localparam int HALL_COUNT_W  = 11;
    localparam int HALL_PERIOD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        FINISH
    } hall_emu_state_t;

    typedef struct packed {
        logic [HALL_COUNT_W-1:0]  pulses;
        logic [HALL_PERIOD_W-1:0] period;
        logic [HALL_PERIOD_W-1:0] width;
    } hall_cfg_t;

    localparam logic [HALL_PERIOD_W-1:0] MIN_PERIOD = HALL_PERIOD_W'(2);
    localparam logic [HALL_PERIOD_W-1:0] ONE_TICK   = HALL_PERIOD_W'(1);

    // A period needs at least one high and one low cycle, so the width is squeezed below it.
    function automatic hall_cfg_t clamp_cfg(input hall_cfg_t raw);
        hall_cfg_t c;
        c = raw;
        if (raw.period < MIN_PERIOD) c.period = MIN_PERIOD;
        if (raw.width == '0)         c.width  = ONE_TICK;
        if (c.width >= c.period)     c.width  = c.period - ONE_TICK;
        return c;
    endfunction

endpackage

// File: rtl/hall_pulse_emulator.sv
// Hall-sensor emulator: emits a programmed train of hall pulses while the motor is enabled,
// freezing in place while it is stopped, for bring-up of the servo path without a motor.
module hall_pulse_emulator
    import motor_pkg::*;
#(
    parameter int COUNT_W  = HALL_COUNT_W,
    parameter int PERIOD_W = HALL_PERIOD_W
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                start,
    input  logic                runEn,
    input  logic [COUNT_W-1:0]  cfgPulses,
    input  logic [PERIOD_W-1:0] cfgPeriod,
    input  logic [PERIOD_W-1:0] cfgWidth,
    output logic                hallOut,
    output logic [COUNT_W-1:0]  pulseCount,
    output logic                busy,
    output logic                done
);

    hall_emu_state_t     state;
    hall_emu_state_t     next_state;
    hall_cfg_t           cfg;
    hall_cfg_t           raw_cfg;
    hall_cfg_t           new_cfg;
    logic [PERIOD_W-1:0] timer;
    logic                timer_done;
    logic                restart;

    always_comb begin
        raw_cfg    = '{pulses: cfgPulses, period: cfgPeriod, width: cfgWidth};
        new_cfg    = clamp_cfg(raw_cfg);
        timer_done = runEn && (timer == '0);
        restart    = start && (state != IDLE);
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = (new_cfg.pulses == '0) ? FINISH : HIGH;
            end
            HIGH: begin
                if (restart || timer_done) next_state = LOW;
            end
            LOW: begin
                if (restart)         next_state = LOW;
                else if (timer_done) next_state = (pulseCount == cfg.pulses) ? FINISH : HIGH;
            end
            FINISH: begin
                if (restart)   next_state = LOW;
                else if (done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // A restart parks in LOW with an expired timer, so the waveform gets one low cycle
    // before the first rising edge of the new train.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cfg        <= '0;
            timer      <= '0;
            hallOut    <= 1'b0;
            pulseCount <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= next_state;
            if (restart) begin
                cfg        <= new_cfg;
                timer      <= '0;
                hallOut    <= 1'b0;
                pulseCount <= '0;
                busy       <= 1'b1;
                done       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            cfg  <= new_cfg;
                            busy <= 1'b1;
                            done <= 1'b0;
                            if (new_cfg.pulses == '0) begin
                                pulseCount <= '0;
                                hallOut    <= 1'b0;
                            end else begin
                                pulseCount <= COUNT_W'(1);
                                hallOut    <= 1'b1;
                                timer      <= new_cfg.width - ONE_TICK;
                            end
                        end
                    end
                    HIGH: begin
                        if (timer_done) begin
                            hallOut <= 1'b0;
                            timer   <= cfg.period - cfg.width - ONE_TICK;
                        end else if (runEn) begin
                            timer <= timer - ONE_TICK;
                        end
                    end
                    LOW: begin
                        if (timer_done) begin
                            if (pulseCount == cfg.pulses) begin
                                done <= 1'b1;
                            end else begin
                                hallOut    <= 1'b1;
                                pulseCount <= pulseCount + COUNT_W'(1);
                                timer      <= cfg.width - ONE_TICK;
                            end
                        end else if (runEn) begin
                            timer <= timer - ONE_TICK;
                        end
                    end
                    FINISH: begin
                        // Arriving straight from IDLE (zero pulses) the strobe has not fired yet.
                        if (done) begin
                            done <= 1'b0;
                            busy <= 1'b0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hall_pulse_emulator.sv
// Directed bench for hall_pulse_emulator: each scenario task drives a start, records the
// per-cycle outputs and compares them against hand-derived pulse-train timing.
module tb_hall_pulse_emulator;

    localparam int CW    = 11;
    localparam int PW    = 16;
    localparam int TRACE = 64;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          start;
    logic          runEn;
    logic [CW-1:0] cfgPulses;
    logic [PW-1:0] cfgPeriod;
    logic [PW-1:0] cfgWidth;
    logic          hallOut;
    logic [CW-1:0] pulseCount;
    logic          busy;
    logic          done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic          hall_tr [TRACE];
    logic [CW-1:0] cnt_tr  [TRACE];
    logic          busy_tr [TRACE];
    logic          done_tr [TRACE];
    logic          en_tr   [TRACE];

    hall_pulse_emulator dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .start      (start),
        .runEn      (runEn),
        .cfgPulses  (cfgPulses),
        .cfgPeriod  (cfgPeriod),
        .cfgWidth   (cfgWidth),
        .hallOut    (hallOut),
        .pulseCount (pulseCount),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Start is held for exactly one cycle; on return the bench sits in cycle 1 of the run.
    task automatic do_start(input int p, input int per, input int w);
        cfgPulses = CW'(p);
        cfgPeriod = PW'(per);
        cfgWidth  = PW'(w);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic capture(input int n, input int off_lo, input int off_hi);
        for (int k = 1; k <= n; k++) begin
            runEn      = !(k >= off_lo && k <= off_hi);
            hall_tr[k] = hallOut;
            cnt_tr[k]  = pulseCount;
            busy_tr[k] = busy;
            done_tr[k] = done;
            en_tr[k]   = runEn;
            tick();
        end
        runEn = 1'b1;
    endtask

    // Ideal train: first rise at cycle s, n pulses of w high cycles every p cycles,
    // done in the cycle right after the last period, busy up to and including that cycle.
    function automatic logic exp_hall(int k, int s, int p, int w, int n);
        if (k < s || n == 0) return 1'b0;
        if ((k - s) / p >= n) return 1'b0;
        return ((k - s) % p) < w;
    endfunction

    function automatic logic [CW-1:0] exp_cnt(int k, int s, int p, int n);
        int i;
        if (k < s) return '0;
        i = (k - s) / p + 1;
        return CW'((i > n) ? n : i);
    endfunction

    task automatic test_reset();
        RESET     = 1'b1;
        start     = 1'b0;
        runEn     = 1'b1;
        cfgPulses = '0;
        cfgPeriod = '0;
        cfgWidth  = '0;
        tick();
        tick();
        tests_run++;
        if ({hallOut, pulseCount, busy, done} !== {1'b0, CW'(0), 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got hall=%b cnt=%0d busy=%b done=%b, expected all zero",
                     hallOut, pulseCount, busy, done);
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_high();
        int done_seen;
        do_start(3, 10, 4);
        capture(2, 100, 0);
        tests_run++;
        if (hallOut !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_high: got hall=%b, expected 1", hallOut);
        end
        #3 RESET = 1'b1;
        #1;
        tests_run++;
        if ({hallOut, pulseCount, busy, done} !== {1'b0, CW'(0), 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got hall=%b cnt=%0d busy=%b done=%b, expected all zero",
                     hallOut, pulseCount, busy, done);
        end
        tick();
        RESET = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (done || busy || hallOut) done_seen++;
            tick();
        end
        tests_run++;
        if (done_seen !== 0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_idle: got %0d active cycles, expected 0", done_seen);
        end
    endtask

    task automatic test_basic_train();
        do_start(3, 10, 4);
        cfgPulses = CW'(7);
        cfgPeriod = PW'(3);
        cfgWidth  = PW'(1);
        capture(33, 100, 0);
        for (int k = 1; k <= 33; k++) begin
            tests_run++;
            if ({hall_tr[k], cnt_tr[k], done_tr[k], busy_tr[k]} !==
                {exp_hall(k, 1, 10, 4, 3), exp_cnt(k, 1, 10, 3), k == 31, k <= 31}) begin
                tests_failed++;
                $display("[TB] FAIL basic_train cycle %0d: got hall=%b cnt=%0d done=%b busy=%b, expected hall=%b cnt=%0d done=%b busy=%b",
                         k, hall_tr[k], cnt_tr[k], done_tr[k], busy_tr[k],
                         exp_hall(k, 1, 10, 4, 3), exp_cnt(k, 1, 10, 3), k == 31, k <= 31);
            end
        end
    endtask

    task automatic test_pause();
        int frozen_high;
        int enabled_high;
        int done_total;
        do_start(3, 10, 4);
        capture(53, 12, 31);
        frozen_high  = 0;
        enabled_high = 0;
        done_total   = 0;
        for (int k = 12; k <= 31; k++) if (hall_tr[k]) frozen_high++;
        for (int k = 11; k <= 40; k++) if (hall_tr[k] && en_tr[k]) enabled_high++;
        for (int k = 1; k <= 53; k++) if (done_tr[k]) done_total++;
        tests_run++;
        if (frozen_high !== 20) begin
            tests_failed++;
            $display("[TB] FAIL pause_hold_high: got %0d high cycles while stopped, expected 20", frozen_high);
        end
        tests_run++;
        if (enabled_high !== 4) begin
            tests_failed++;
            $display("[TB] FAIL pause_width: got %0d enabled high cycles, expected 4", enabled_high);
        end
        tests_run++;
        if ({hall_tr[34], hall_tr[35], hall_tr[41]} !== 3'b101) begin
            tests_failed++;
            $display("[TB] FAIL pause_edges: got hall34/35/41=%b%b%b, expected 101",
                     hall_tr[34], hall_tr[35], hall_tr[41]);
        end
        tests_run++;
        if ({done_tr[31], done_tr[51], cnt_tr[51], busy_tr[52]} !== {1'b0, 1'b1, CW'(3), 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL pause_done: got done31=%b done51=%b cnt51=%0d busy52=%b, expected 0 1 3 0",
                     done_tr[31], done_tr[51], cnt_tr[51], busy_tr[52]);
        end
        tests_run++;
        if (done_total !== 1) begin
            tests_failed++;
            $display("[TB] FAIL pause_done_count: got %0d strobes, expected 1", done_total);
        end
    endtask

    task automatic test_clamp();
        do_start(2, 1, 0);
        capture(7, 100, 0);
        for (int k = 1; k <= 7; k++) begin
            tests_run++;
            if ({hall_tr[k], cnt_tr[k], done_tr[k], busy_tr[k]} !==
                {exp_hall(k, 1, 2, 1, 2), exp_cnt(k, 1, 2, 2), k == 5, k <= 5}) begin
                tests_failed++;
                $display("[TB] FAIL clamp_min cycle %0d: got hall=%b cnt=%0d done=%b busy=%b, expected hall=%b cnt=%0d done=%b busy=%b",
                         k, hall_tr[k], cnt_tr[k], done_tr[k], busy_tr[k],
                         exp_hall(k, 1, 2, 1, 2), exp_cnt(k, 1, 2, 2), k == 5, k <= 5);
            end
        end
        do_start(1, 5, 9);
        capture(8, 100, 0);
        for (int k = 1; k <= 8; k++) begin
            tests_run++;
            if ({hall_tr[k], cnt_tr[k], done_tr[k], busy_tr[k]} !==
                {exp_hall(k, 1, 5, 4, 1), exp_cnt(k, 1, 5, 1), k == 6, k <= 6}) begin
                tests_failed++;
                $display("[TB] FAIL clamp_width cycle %0d: got hall=%b cnt=%0d done=%b busy=%b, expected hall=%b cnt=%0d done=%b busy=%b",
                         k, hall_tr[k], cnt_tr[k], done_tr[k], busy_tr[k],
                         exp_hall(k, 1, 5, 4, 1), exp_cnt(k, 1, 5, 1), k == 6, k <= 6);
            end
        end
    endtask

    task automatic test_zero_pulses();
        do_start(0, 10, 4);
        capture(4, 100, 0);
        tests_run++;
        if ({hall_tr[1], hall_tr[2], hall_tr[3], hall_tr[4]} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL zero_hall: got %b%b%b%b, expected 0000",
                     hall_tr[1], hall_tr[2], hall_tr[3], hall_tr[4]);
        end
        tests_run++;
        if ({done_tr[1], done_tr[2], done_tr[3], busy_tr[1], busy_tr[2], busy_tr[3]} !== 6'b010_110) begin
            tests_failed++;
            $display("[TB] FAIL zero_done: got done=%b%b%b busy=%b%b%b, expected done=010 busy=110",
                     done_tr[1], done_tr[2], done_tr[3], busy_tr[1], busy_tr[2], busy_tr[3]);
        end
        tests_run++;
        if ({cnt_tr[1], cnt_tr[2], cnt_tr[4]} !== {CW'(0), CW'(0), CW'(0)}) begin
            tests_failed++;
            $display("[TB] FAIL zero_count: got %0d %0d %0d, expected 0 0 0", cnt_tr[1], cnt_tr[2], cnt_tr[4]);
        end
    endtask

    task automatic test_restart();
        int done_total;
        do_start(3, 10, 4);
        capture(11, 100, 0);
        tests_run++;
        if ({hallOut, pulseCount} !== {1'b1, CW'(2)}) begin
            tests_failed++;
            $display("[TB] FAIL restart_pre: got hall=%b cnt=%0d, expected hall=1 cnt=2", hallOut, pulseCount);
        end
        do_start(2, 6, 3);
        capture(15, 100, 0);
        done_total = 0;
        for (int k = 1; k <= 15; k++) begin
            if (done_tr[k]) done_total++;
            tests_run++;
            if ({hall_tr[k], cnt_tr[k], done_tr[k], busy_tr[k]} !==
                {exp_hall(k, 2, 6, 3, 2), exp_cnt(k, 2, 6, 2), k == 14, k <= 14}) begin
                tests_failed++;
                $display("[TB] FAIL restart cycle %0d: got hall=%b cnt=%0d done=%b busy=%b, expected hall=%b cnt=%0d done=%b busy=%b",
                         k, hall_tr[k], cnt_tr[k], done_tr[k], busy_tr[k],
                         exp_hall(k, 2, 6, 3, 2), exp_cnt(k, 2, 6, 2), k == 14, k <= 14);
            end
        end
        tests_run++;
        if (done_total !== 1) begin
            tests_failed++;
            $display("[TB] FAIL restart_done_count: got %0d strobes, expected 1", done_total);
        end
    endtask

    task automatic test_back_to_back();
        do_start(1, 2, 1);
        capture(2, 100, 0);
        tests_run++;
        if ({done, busy} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL b2b_finish: got done=%b busy=%b, expected 1 1", done, busy);
        end
        do_start(1, 2, 1);
        capture(5, 100, 0);
        for (int k = 1; k <= 5; k++) begin
            tests_run++;
            if ({hall_tr[k], cnt_tr[k], done_tr[k], busy_tr[k]} !==
                {exp_hall(k, 2, 2, 1, 1), exp_cnt(k, 2, 2, 1), k == 4, k <= 4}) begin
                tests_failed++;
                $display("[TB] FAIL b2b cycle %0d: got hall=%b cnt=%0d done=%b busy=%b, expected hall=%b cnt=%0d done=%b busy=%b",
                         k, hall_tr[k], cnt_tr[k], done_tr[k], busy_tr[k],
                         exp_hall(k, 2, 2, 1, 1), exp_cnt(k, 2, 2, 1), k == 4, k <= 4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_high();
        test_basic_train();
        test_pause();
        test_clamp();
        test_zero_pulses();
        test_restart();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
